// File: rtl/tx_ch_sequencer_pkg.sv
// Shared definitions for the Tx/channel run sequencer: state encoding and flush-length derivation.
package tx_ch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2,
        ST_STOP  = 2'd3
    } seq_state_t;

    localparam int DEF_OVERSAMP    = 4;
    localparam int DEF_NB_PHASE    = $clog2(DEF_OVERSAMP);
    localparam int NBAUD           = 6;
    localparam int NUM_CHFILT_COEF = 17;

    // Tx filter span plus channel FIR taps, rounded up to whole symbols so RUN begins at phase 0.
    function automatic int flush_cycles(input int nbaud, input int ncoef, input int oversamp);
        return ((nbaud * oversamp + ncoef + oversamp - 1) / oversamp) * oversamp;
    endfunction

    localparam int DEF_FLUSH_CYC = flush_cycles(NBAUD, NUM_CHFILT_COEF, DEF_OVERSAMP);

endpackage

// File: rtl/tx_ch_sequencer_phase_counter.sv
// Modulo-OVERSAMP phase counter with synchronous clear and a registered end-of-symbol strobe.
module tx_ch_sequencer_phase_counter #(
    parameter int OVERSAMP = 4,
    parameter int NB_PHASE = 2
) (
    input  logic                clk,
    input  logic                srst_i,
    input  logic                clr_i,
    input  logic                inc_i,
    input  logic                strb_en_i,
    output logic [NB_PHASE-1:0] phase_o,
    output logic [NB_PHASE-1:0] phase_next_o,
    output logic                wrap_o
);

    localparam logic [NB_PHASE-1:0] PHASE_LAST = NB_PHASE'(OVERSAMP - 1);

    logic [NB_PHASE-1:0] phase_q, phase_d;
    logic                wrap_q, wrap_d;

    always_comb begin
        phase_d = phase_q;
        if (clr_i) begin
            phase_d = '0;
        end else if (inc_i) begin
            phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + NB_PHASE'(1);
        end
        // Strobe is registered together with the phase it belongs to.
        wrap_d = strb_en_i && (phase_d == PHASE_LAST);
    end

    always_ff @(posedge clk) begin
        if (srst_i) begin
            phase_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
        end
    end

    assign phase_o      = phase_q;
    assign phase_next_o = phase_d;
    assign wrap_o       = wrap_q;

endmodule

// File: rtl/tx_ch_sequencer.sv
// Run controller for the Tx -> noise -> channel-filter chain: IDLE/FLUSH/RUN/STOP sequencing.
// Optional run-length limit enabled by defining TX_CH_SEQ_RUN_LIMIT_EN.
module tx_ch_sequencer
    import tx_ch_sequencer_pkg::*;
#(
    parameter int OVERSAMP   = DEF_OVERSAMP,
    parameter int NB_PHASE   = DEF_NB_PHASE,
    parameter int FLUSH_CYC  = DEF_FLUSH_CYC,
    parameter int NB_FLUSH   = 8,
    parameter int NB_SYM_CNT = 32
`ifdef TX_CH_SEQ_RUN_LIMIT_EN
    ,
    parameter int RUN_SYMS   = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_noise_en,
    input  logic [NB_PHASE-1:0]   i_ds_phase,
    output logic [NB_PHASE-1:0]   o_phase,
    output logic                  o_sym_strobe,
    output logic                  o_dp_enable,
    output logic                  o_noise_en,
    output logic                  o_valid,
    output logic                  o_ds_strobe,
    output logic [NB_SYM_CNT-1:0] o_sym_count,
    output logic [1:0]            o_state,
    output logic                  o_done
);

    localparam logic [NB_PHASE-1:0] PHASE_LAST = NB_PHASE'(OVERSAMP - 1);
    localparam logic [NB_FLUSH-1:0] FLUSH_LAST = NB_FLUSH'(FLUSH_CYC - 1);

    seq_state_t            state_q, state_d;
    logic [NB_FLUSH-1:0]   flush_q, flush_d;
    logic [NB_PHASE-1:0]   ds_lat_q, ds_lat_d;
    logic [NB_SYM_CNT-1:0] count_q, count_d;
    logic                  dp_en_q, dp_en_d;
    logic                  valid_q, valid_d;
    logic                  ds_strobe_q, ds_strobe_d;
    logic                  noise_q, noise_d;
    logic                  done_q;
    logic                  run_limit_hit;
    logic [NB_PHASE-1:0]   phase_q, phase_next;
    logic                  sym_strobe_q;
    logic [NB_PHASE-1:0]   ds_clamp;
    int unsigned           ds_req;

    tx_ch_sequencer_phase_counter #(
        .OVERSAMP (OVERSAMP),
        .NB_PHASE (NB_PHASE)
    ) u_phase (
        .clk          (clk),
        .srst_i       (i_reset),
        .clr_i        ((state_q == ST_IDLE) || (state_d == ST_IDLE)),
        .inc_i        (dp_en_q),
        .strb_en_i    (state_d != ST_IDLE),
        .phase_o      (phase_q),
        .phase_next_o (phase_next),
        .wrap_o       (sym_strobe_q)
    );

`ifdef TX_CH_SEQ_RUN_LIMIT_EN
    assign run_limit_hit = (state_q == ST_RUN) && (count_q >= NB_SYM_CNT'(RUN_SYMS));

    // Sticky until the run request drops, which also blocks an automatic restart from IDLE.
    always_ff @(posedge clk) begin
        if (i_reset || !i_enable) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_q | run_limit_hit;
        end
    end
`else
    assign run_limit_hit = 1'b0;
    assign done_q        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_enable && !done_q) state_d = ST_FLUSH;
            ST_FLUSH: begin
                if (!i_enable)                state_d = ST_IDLE;
                else if (flush_q == FLUSH_LAST) state_d = ST_RUN;
            end
            ST_RUN:   if (!i_enable || run_limit_hit) state_d = ST_STOP;
            ST_STOP:  if (phase_q == PHASE_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ds_req   = 32'(i_ds_phase);
        ds_clamp = (ds_req >= 32'(OVERSAMP)) ? PHASE_LAST : i_ds_phase;

        flush_d  = ((state_q == ST_FLUSH) && (state_d == ST_FLUSH)) ? flush_q + NB_FLUSH'(1) : '0;
        ds_lat_d = ((state_q == ST_FLUSH) && (state_d == ST_RUN)) ? ds_clamp : ds_lat_q;

        count_d = count_q;
        if ((state_q == ST_IDLE) && (state_d == ST_FLUSH)) begin
            count_d = '0;
        end else if ((state_q == ST_RUN) && sym_strobe_q && (count_q != '1)) begin
            count_d = count_q + NB_SYM_CNT'(1);
        end

        dp_en_d     = (state_d != ST_IDLE);
        valid_d     = (state_d == ST_RUN) || (state_d == ST_STOP);
        ds_strobe_d = valid_d && (phase_next == ds_lat_d);
        // Noise request is only sampled at symbol boundaries.
        noise_d     = (state_d == ST_IDLE) ? 1'b0 : (sym_strobe_q ? i_noise_en : noise_q);
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            flush_q     <= '0;
            ds_lat_q    <= '0;
            count_q     <= '0;
            dp_en_q     <= 1'b0;
            valid_q     <= 1'b0;
            ds_strobe_q <= 1'b0;
            noise_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            ds_lat_q    <= ds_lat_d;
            count_q     <= count_d;
            dp_en_q     <= dp_en_d;
            valid_q     <= valid_d;
            ds_strobe_q <= ds_strobe_d;
            noise_q     <= noise_d;
        end
    end

    assign o_phase      = phase_q;
    assign o_sym_strobe = sym_strobe_q;
    assign o_dp_enable  = dp_en_q;
    assign o_noise_en   = noise_q;
    assign o_valid      = valid_q;
    assign o_ds_strobe  = ds_strobe_q;
    assign o_sym_count  = count_q;
    assign o_state      = state_q;
    assign o_done       = done_q;

endmodule
